mbist_wb_bridge: RTL and testbench
==================================

MBIST_WB_BRIDGE -- requirements
Module: mbist_wb_bridge

Interface
REQ-001 SHALL have parameter BIST_NO_SRAM, default 4, number of SRAM instances addressed.
REQ-002 SHALL have parameter BIST_ADDR_WD, default 10, SRAM word-address width.
REQ-003 SHALL have parameter BIST_DATA_WD, default 32, SRAM data width.
REQ-004 SHALL define CS_WD = (BIST_NO_SRAM+1)/2 and AW = BIST_ADDR_WD+CS_WD+2 as derived widths.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- wb_clk_i  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  wishbone cycle
- wb_stb_i  in  1  wishbone strobe
- wb_we_i  in  1  1=write, 0=read
- wb_adr_i  in  AW  byte address
- wb_dat_i  in  BIST_DATA_WD  write data
- wb_sel_i  in  BIST_DATA_WD/8  byte select
- wb_dat_o  out  BIST_DATA_WD  read data
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  transfer error (bad SRAM index)
- bist_en  in  1  MBIST owns memories; new requests stalled
- mem_cs  out  CS_WD  SRAM select index
- mem_req  out  1  memory request strobe
- mem_addr  out  BIST_ADDR_WD  word address
- mem_we  out  1  memory write
- mem_wdata  out  BIST_DATA_WD  write data
- mem_wmask  out  BIST_DATA_WD/8  byte mask
- mem_rdata  in  BIST_DATA_WD  read data, valid one cycle after mem_req

Function
REQ-006 SHALL implement FSM states IDLE, REQ, RDWAIT, ACK, ERR.
REQ-007 IDLE SHALL accept a transfer when wb_cyc_i & wb_stb_i & !bist_en, registering we, address, data, sel.
REQ-008 Decode: mem_addr = wb_adr_i[BIST_ADDR_WD+1:2]; mem_cs = wb_adr_i[AW-1:BIST_ADDR_WD+2]; bits [1:0] ignored.
REQ-009 If decoded mem_cs >= BIST_NO_SRAM, IDLE SHALL go to ERR; else to REQ.
REQ-010 REQ SHALL assert mem_req=1 for exactly one cycle with registered mem_cs/mem_addr/mem_we/mem_wdata/mem_wmask; next state ACK if write, RDWAIT if read.
REQ-011 RDWAIT SHALL capture mem_rdata into wb_dat_o at end of cycle; next ACK.
REQ-012 ACK SHALL drive wb_ack_o = wb_cyc_i for one cycle; next IDLE.
REQ-013 ERR SHALL drive wb_err_o = wb_cyc_i for one cycle, no mem_req; next IDLE.
REQ-014 Latency from accepting edge: write ack 2 cycles, read ack 3 cycles, error 1 cycle.
REQ-015 wb_dat_o SHALL hold the last read value until the next read completes; writes do not alter it.
REQ-016 wb_ack_o and wb_err_o SHALL never be asserted together, nor outside ACK/ERR.
REQ-017 bist_en rising during REQ/RDWAIT/ACK SHALL NOT abort the in-flight transfer; only IDLE acceptance is blocked.
REQ-018 wb_cyc_i dropping mid-transfer SHALL let the memory access complete, with the ack/err suppressed.
REQ-019 mem_* outputs outside REQ SHALL hold last values with mem_req=0.
REQ-020 A new transfer SHALL NOT be accepted in the ACK/ERR cycle; minimum one IDLE cycle between transfers.

Reset
REQ-021 On rst_n low, state SHALL go to IDLE asynchronously; all outputs 0 (mem_req=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mem_cs=0, mem_addr=0).
REQ-022 Reset mid-transfer SHALL abort it; no ack/err is issued after release.

Structure
REQ-023 The state enum and CS_WD/AW derivation SHALL live in shared package mbist_pkg.
REQ-024 The block SHALL be a single module with no sub-module; it feeds the existing SRAM memory-wrapper inputs directly.

Verification
REQ-025 Write adr=0x0000_0404, dat=0xDEADBEEF, sel=0xF, defaults: mem_req 1 cycle with mem_cs=0, mem_addr=0x101, mem_we=1; ack 2 cycles after accept.
REQ-026 Read adr=0x0000_0404, mem_rdata=0x12345678 one cycle after mem_req: wb_dat_o=0x12345678 with ack 3 cycles after accept.
REQ-027 BIST_NO_SRAM=3, adr with cs=3: wb_err_o 1 cycle after accept, no mem_req, no ack.
REQ-028 bist_en=1 with stb held 10 cycles: no mem_req, no ack; bist_en drops: access proceeds, normal latency.
REQ-029 rst_n low during RDWAIT: all outputs 0 immediately; no ack after release; next read completes normally.
REQ-030 Back-to-back writes cs=1 then cs=2: each ack single-cycle, one IDLE cycle between, mem_cs matches each.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and derived widths for the MBIST wishbone bridge.
// Keeps the FSM encoding and address-field widths in one place.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RDWAIT,
    ACK,
    ERR
  } state_t;

  function automatic int cs_wd(input int n_sram);
    return (n_sram + 1) / 2;
  endfunction

  function automatic int aw(input int addr_wd, input int n_sram);
    return addr_wd + cs_wd(n_sram) + 2;
  endfunction

endpackage

// File: rtl/mbist_wb_bridge.sv
// Wishbone slave that turns single transfers into one-cycle SRAM requests
// toward the MBIST memory wrappers; stalls new work while MBIST owns them.
module mbist_wb_bridge
  import mbist_pkg::*;
#(
  parameter int BIST_NO_SRAM = 4,
  parameter int BIST_ADDR_WD = 10,
  parameter int BIST_DATA_WD = 32,
  localparam int CS_WD = cs_wd(BIST_NO_SRAM),
  localparam int AW    = aw(BIST_ADDR_WD, BIST_NO_SRAM),
  localparam int SW    = BIST_DATA_WD / 8
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [AW-1:0]           wb_adr_i,
  input  logic [BIST_DATA_WD-1:0] wb_dat_i,
  input  logic [SW-1:0]           wb_sel_i,
  output logic [BIST_DATA_WD-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  input  logic                    bist_en,
  output logic [CS_WD-1:0]        mem_cs,
  output logic                    mem_req,
  output logic [BIST_ADDR_WD-1:0] mem_addr,
  output logic                    mem_we,
  output logic [BIST_DATA_WD-1:0] mem_wdata,
  output logic [SW-1:0]           mem_wmask,
  input  logic [BIST_DATA_WD-1:0] mem_rdata
);

  state_t state;
  state_t state_nx;

  logic [CS_WD-1:0]        dec_cs;
  logic [BIST_ADDR_WD-1:0] dec_addr;
  logic                    cs_bad;
  logic                    accept;
  logic                    load;
  logic                    adr_unused;

  assign dec_cs   = wb_adr_i[AW-1:BIST_ADDR_WD+2];
  assign dec_addr = wb_adr_i[BIST_ADDR_WD+1:2];
  assign cs_bad   = 32'(dec_cs) >= 32'(BIST_NO_SRAM);
  assign accept   = wb_cyc_i & wb_stb_i & ~bist_en;
  assign load     = (state == IDLE) & accept & ~cs_bad;

  // Byte offset is meaningless for word-wide SRAMs.
  assign adr_unused = ^wb_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = cs_bad ? ERR : REQ;
      end
      REQ:     state_nx = mem_we ? ACK : RDWAIT;
      RDWAIT:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    unique case (1'b1)
      (state == REQ): mem_req  = 1'b1;
      (state == ACK): wb_ack_o = wb_cyc_i;
      (state == ERR): wb_err_o = wb_cyc_i;
      default: ;
    endcase
  end

  // Memory-side fields only move on a valid accept, so they hold otherwise.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mem_cs    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (load) begin
      mem_cs    <= dec_cs;
      mem_addr  <= dec_addr;
      mem_we    <= wb_we_i;
      mem_wdata <= wb_dat_i;
      mem_wmask <= wb_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)                wb_dat_o <= '0;
    else if (state == RDWAIT)  wb_dat_o <= mem_rdata;
  end

endmodule

// File: tb/tb_mbist_wb_bridge.sv
// Scoreboard bench for mbist_wb_bridge with three SRAMs so that
// cs=3 exercises the bad-index error path.
module tb_mbist_wb_bridge;

  localparam int NS = 3;
  localparam int AWD = 10;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] wdat = '0;
  logic [3:0]    sel = '0;
  logic [DW-1:0] rdat;
  logic          ack;
  logic          err;
  logic          bist_en = 1'b0;
  logic [CW-1:0] mem_cs;
  logic          mem_req;
  logic [AWD-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic [DW-1:0] mem_rdata = '0;

  mbist_wb_bridge #(
    .BIST_NO_SRAM(NS),
    .BIST_ADDR_WD(AWD),
    .BIST_DATA_WD(DW)
  ) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .bist_en  (bist_en),
    .mem_cs   (mem_cs),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [31:0] data;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [CW-1:0]  cs;
    logic [AWD-1:0] addr;
    logic           we;
    logic [31:0]    wdata;
    logic [3:0]     wmask;
  } mrq_t;

  rsp_t rsp_q[$];
  mrq_t mrq_q[$];

  logic [31:0] mem    [4][1024];
  logic [31:0] shadow [4][1024];
  logic [31:0] last_rd = '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 1024; a++) begin
        mem[c][a]    = 32'hA500_0000 ^ (c << 16) ^ a;
        shadow[c][a] = 32'hA500_0000 ^ (c << 16) ^ a;
      end
    mem[0][10'h101]    = 32'h1234_5678;
    shadow[0][10'h101] = 32'h1234_5678;
  end

  // SRAM model: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b])
            mem[mem_cs][mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_cs][mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_err_excl", 32'(ack & err), 32'd0);
      if (mem_req) begin
        if (mrq_q.size() == 0) begin
          chk("mreq_unexp", 32'd1, 32'd0);
        end else begin
          mrq_t m;
          m = mrq_q.pop_front();
          chk("mem_cs", 32'(mem_cs), 32'(m.cs));
          chk("mem_addr", 32'(mem_addr), 32'(m.addr));
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_wdata", mem_wdata, m.wdata);
          chk("mem_wmask", 32'(mem_wmask), 32'(m.wmask));
        end
      end
    end
  end

  task automatic start(input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int lat);
    logic [CW-1:0]  c;
    logic [AWD-1:0] wa;
    bit             bad;
    rsp_t           r;
    mrq_t           m;
    c   = a[AW-1:AWD+2];
    wa  = a[AWD+1:2];
    bad = (int'(c) >= NS);
    if (!bad) begin
      m.cs = c; m.addr = wa; m.we = w; m.wdata = d; m.wmask = s;
      mrq_q.push_back(m);
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) shadow[c][wa][8*b +: 8] = d[8*b +: 8];
    end
    r.is_err = bad;
    r.is_rd  = !w && !bad;
    r.data   = bad ? 32'h0 : shadow[c][wa];
    r.lat    = lat;
    rsp_q.push_back(r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic finish(input bit keep);
    int   n;
    rsp_t r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack || err) && n < 20);
    if (rsp_q.size() == 0) begin
      chk("rsp_q_empty", 32'd1, 32'd0);
    end else begin
      r = rsp_q.pop_front();
      chk("latency", 32'(n), 32'(r.lat));
      chk("ack", 32'(ack), 32'(!r.is_err));
      chk("err", 32'(err), 32'(r.is_err));
      if (r.is_rd) begin
        chk("rdata", rdat, r.data);
        last_rd = r.data;
      end else begin
        chk("dat_hold", rdat, last_rd);
      end
    end
    if (!keep) begin
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic saw;
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      saw = saw | ack | err;
    end
    chk(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    rsp_t dropped;

    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    start(1'b0, 14'h0404, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b1, 14'h0404, 32'hDEAD_BEEF, 4'hF, 2);
    finish(0);

    @(negedge clk);
    start(1'b0, 14'h0404, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b1, 14'h0404, 32'h1111_2222, 4'h3, 2);
    finish(0);
    @(negedge clk);
    start(1'b0, 14'h0404, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b1, 14'h3010, 32'hCAFE_F00D, 4'hF, 1);
    finish(0);
    quiet("err_no_ack", 2);

    @(negedge clk);
    bist_en = 1'b1;
    start(1'b1, 14'h2044, 32'h0BAD_CAFE, 4'hF, 2);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | mem_req | ack | err;
    end
    chk("bist_stall", 32'(saw), 32'd0);
    bist_en = 1'b0;
    finish(0);
    @(negedge clk);
    start(1'b0, 14'h2044, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b1, 14'h1080, 32'h5A5A_A5A5, 4'hF, 0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    quiet("cyc_drop", 3);
    dropped = rsp_q.pop_front();
    @(negedge clk);
    start(1'b0, 14'h1080, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b0, 14'h2014, 32'h0, 4'hF, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_mreq", 32'(mem_req), 32'd0);
    chk("arst_dat", rdat, 32'd0);
    chk("arst_cs", 32'(mem_cs), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    dropped = rsp_q.pop_front();
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet("post_rst", 4);
    start(1'b0, 14'h2014, 32'h0, 4'hF, 3);
    finish(0);

    @(negedge clk);
    start(1'b1, 14'h101C, 32'h1357_9BDF, 4'hF, 2);
    finish(1);
    start(1'b1, 14'h2024, 32'h2468_ACE0, 4'hF, 3);
    finish(0);
    @(negedge clk);
    start(1'b0, 14'h101C, 32'h0, 4'hF, 3);
    finish(0);
    @(negedge clk);
    start(1'b0, 14'h2024, 32'h0, 4'hF, 3);
    finish(0);

    repeat (2) @(negedge clk);
    chk("mreq_q_drained", 32'(mrq_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
